read_xadc_axil_slave: RTL and testbench
=======================================

Name: read_xadc_axil_slave

Overview:
- AXI4-Lite slave register file for the read_xadc IP; responder end of the S00_AXI interface that the master VIP drives.
- Holds four software R/W registers (control plus scratch) and read-only XADC sample/status registers.
- Captures 16-bit conversion results returned by the XADC DRP port (do/drdy) when capture is enabled.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
- C_SAMPLE_WIDTH, 16, width of xadc_do.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  always OKAY (2'b00).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- xadc_do  in  C_SAMPLE_WIDTH  DRP read data.
- xadc_drdy  in  1  DRP data-valid pulse.
- irq  out  1  new-sample interrupt; level, see Optional Feature.

Behaviour:
- Reset: all READY/VALID low; RDATA, BRESP and RRESP 0; all registers 0; irq 0.
- Register map (word index = addr[4:2]; addr[1:0] ignored):
  - 0: CTRL, R/W. bit0 capture_en, bit1 irq_en, bit2 clr_cnt (self-clearing; reads 0).
  - 1–3: SCRATCH1..3, R/W, full 32 bits.
  - 4: SAMPLE, RO. Last captured xadc_do, zero-extended.
  - 5: COUNT, RO. 32-bit captured-sample count, wraps 0xFFFFFFFF→0.
  - 6: STATUS, RO. bit0 new_sample sticky flag; cleared when SAMPLE is read.
  - 7: reads 0.
- Write path:
  - AW and W are accepted independently. AWREADY pulses for 1 cycle when AWVALID is high, no address is latched and BVALID is low; WREADY follows the same rule for W.
  - Register update occurs the cycle after both are latched. Only bytes with WSTRB set are written. Writes to RO or reserved words are discarded, still OKAY.
  - BVALID rises in the same cycle as the update and holds until BREADY. No new AW/W is accepted while BVALID is high.
- Read path:
  - ARREADY pulses for 1 cycle when ARVALID is high and RVALID is low.
  - RDATA/RVALID are registered the next cycle. RVALID and RDATA hold stable until RREADY.
  - Read latency is 1 cycle after the AR handshake; one read is outstanding at most.
- Capture: when xadc_drdy=1 and capture_en=1, SAMPLE←xadc_do, COUNT+1, new_sample←1, all in the same cycle. xadc_drdy with capture_en=0 is ignored.
- Simultaneous events:
  - clr_cnt write and capture in the same cycle: COUNT←1. The clear applies, then the capture increment.
  - SAMPLE read (AR handshake) and capture in the same cycle: new_sample stays 1.
- Reset asserted mid-transaction: all state clears immediately and asynchronously. An in-flight response is dropped.

Optional Feature:
- Macro READ_XADC_IRQ_EN.
- Defined: irq is a registered output, irq = new_sample & irq_en.
- Undefined: irq tied 0, and CTRL bit1 reads 0 and is not writable.

Decomposition:
- Package read_xadc_pkg holds:
  - register index constants (REG_CTRL=0 … REG_STATUS=6);
  - CTRL bit positions;
  - RESP_OKAY constant;
  - a typedef for the 32-bit register word.
- One sub-module, read_xadc_sample_cap: capture_en, clr_cnt, xadc_do/drdy → SAMPLE, COUNT, new_sample, with the clear-on-read input.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00–0x0C, then read back → CTRL reads 0x1 (clr_cnt masked), SCRATCH reads 0x2/0x3/0x4, all BRESP/RRESP=0.
- Write 0xAABBCCDD to 0x04 with WSTRB=4'b0101 over a prior value of 0 → read 0x00BB00DD.
- CTRL=1, three drdy pulses with do=0x0123,0x0456,0x0789 → SAMPLE=0x789, COUNT=3, STATUS=1. A second STATUS read after the SAMPLE read gives 0.
- Apply AW 3 cycles before W, and separately W before AW → exactly one write each, BVALID held 5 cycles while BREADY=0, no second acceptance meanwhile.
- Write CTRL=0x5 in the same cycle as a drdy pulse → COUNT=1.
- Build with READ_XADC_IRQ_EN, CTRL=0x3, one capture → irq=1 one cycle later, cleared after the SAMPLE read. Build without the macro → irq stays 0.

Source files
------------

// File: rtl/read_xadc_axil_slave_pkg.sv
// Shared types and constants for the read_xadc AXI4-Lite register file.
// READ_XADC_IRQ_EN makes CTRL.irq_en a writable bit.
package read_xadc_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  reg_idx_t;

  localparam reg_idx_t REG_CTRL     = 3'd0;
  localparam reg_idx_t REG_SCRATCH1 = 3'd1;
  localparam reg_idx_t REG_SCRATCH2 = 3'd2;
  localparam reg_idx_t REG_SCRATCH3 = 3'd3;
  localparam reg_idx_t REG_SAMPLE   = 3'd4;
  localparam reg_idx_t REG_COUNT    = 3'd5;
  localparam reg_idx_t REG_STATUS   = 3'd6;

  localparam int CTRL_CAP_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLR_CNT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef READ_XADC_IRQ_EN
  localparam word_t CTRL_RW_MASK = 32'h0000_0003;
`else
  localparam word_t CTRL_RW_MASK = 32'h0000_0001;
`endif

  function automatic word_t apply_strb(
    input word_t      old_v,
    input word_t      new_v,
    input logic [3:0] strb
  );
    word_t r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/read_xadc_axil_slave_if.sv
// AXI4-Lite S00_AXI bundle between the master VIP and the register file.
// Signal names follow the Xilinx S_AXI_* naming.
interface read_xadc_axil_slave_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/read_xadc_axil_slave_sample_cap.sv
// XADC DRP sample capture: last sample, wrapping sample count and
// a sticky new-sample flag cleared when SAMPLE is read.
module read_xadc_sample_cap
  import read_xadc_pkg::*;
#(
  parameter int C_SAMPLE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_capture_en,
  input  logic                      i_clr_cnt,
  input  logic                      i_rd_clr,
  input  logic                      i_drdy,
  input  logic [C_SAMPLE_WIDTH-1:0] i_do,
  output logic [C_SAMPLE_WIDTH-1:0] o_sample,
  output word_t                     o_count,
  output logic                      o_new_sample
);

  logic                      w_cap;
  logic [C_SAMPLE_WIDTH-1:0] r_sample;
  word_t                     r_count;
  logic                      r_new;

  assign w_cap = i_drdy & i_capture_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_count  <= '0;
      r_new    <= 1'b0;
    end else begin
      if (w_cap) r_sample <= i_do;
      // clear first, then count the capture landing in the same cycle
      if (i_clr_cnt)  r_count <= w_cap ? 32'd1 : 32'd0;
      else if (w_cap) r_count <= r_count + 32'd1;
      if (w_cap)         r_new <= 1'b1;
      else if (i_rd_clr) r_new <= 1'b0;
    end
  end

  assign o_sample     = r_sample;
  assign o_count      = r_count;
  assign o_new_sample = r_new;

endmodule

// File: rtl/read_xadc_axil_slave.sv
// AXI4-Lite register file for the read_xadc IP (CTRL, scratch, XADC sample).
// Define READ_XADC_IRQ_EN to enable the registered new-sample irq.
module read_xadc_axil_slave
  import read_xadc_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_SAMPLE_WIDTH     = 16
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  read_xadc_axil_slave_if.slave     s_axi,
  input  logic [C_SAMPLE_WIDTH-1:0] xadc_do,
  input  logic                      xadc_drdy,
  output logic                      irq
);

  logic       r_awready;
  logic       r_wready;
  logic       r_bvalid;
  logic       r_arready;
  logic       r_rvalid;
  logic       r_aw_lat;
  logic       r_w_lat;
  reg_idx_t   r_aw_idx;
  word_t      r_wdata;
  logic [3:0] r_wstrb;
  word_t      r_rdata;

  word_t r_ctrl;
  word_t r_scr1;
  word_t r_scr2;
  word_t r_scr3;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_wr_en;
  logic                      w_clr_cnt;
  logic                      w_rd_clr;
  reg_idx_t                  w_ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
  logic [C_SAMPLE_WIDTH-1:0] w_sample;
  word_t                     w_count;
  logic                      w_new_sample;
  logic                      w_unused;

  assign w_aw_hs  = s_axi.S_AXI_AWVALID & r_awready;
  assign w_w_hs   = s_axi.S_AXI_WVALID & r_wready;
  assign w_ar_hs  = s_axi.S_AXI_ARVALID & r_arready;
  assign w_wr_en  = r_aw_lat & r_w_lat & ~r_bvalid;
  assign w_ar_idx = s_axi.S_AXI_ARADDR[4:2];

  assign w_clr_cnt = w_wr_en & (r_aw_idx == REG_CTRL)
                   & r_wstrb[0] & r_wdata[CTRL_CLR_CNT];
  assign w_rd_clr  = w_ar_hs & (w_ar_idx == REG_SAMPLE);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_aw_lat  <= 1'b0;
      r_w_lat   <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_awready <= s_axi.S_AXI_AWVALID & ~r_awready
                 & ~r_aw_lat & ~r_bvalid;
      r_wready  <= s_axi.S_AXI_WVALID & ~r_wready
                 & ~r_w_lat & ~r_bvalid;
      if (w_aw_hs) begin
        r_aw_lat <= 1'b1;
        r_aw_idx <= s_axi.S_AXI_AWADDR[4:2];
      end
      if (w_w_hs) begin
        r_w_lat <= 1'b1;
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_wr_en) begin
        r_aw_lat <= 1'b0;
        r_w_lat  <= 1'b0;
        r_bvalid <= 1'b1;
      end else if (r_bvalid & s_axi.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // clr_cnt is never stored; it only exists as the w_clr_cnt pulse
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_ctrl <= '0;
      r_scr1 <= '0;
      r_scr2 <= '0;
      r_scr3 <= '0;
    end else if (w_wr_en) begin
      case (r_aw_idx)
        REG_CTRL:
          r_ctrl <= apply_strb(r_ctrl, r_wdata, r_wstrb) & CTRL_RW_MASK;
        REG_SCRATCH1: r_scr1 <= apply_strb(r_scr1, r_wdata, r_wstrb);
        REG_SCRATCH2: r_scr2 <= apply_strb(r_scr2, r_wdata, r_wstrb);
        REG_SCRATCH3: r_scr3 <= apply_strb(r_scr3, r_wdata, r_wstrb);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_ar_idx)
      REG_CTRL:     w_rdata = r_ctrl;
      REG_SCRATCH1: w_rdata = r_scr1;
      REG_SCRATCH2: w_rdata = r_scr2;
      REG_SCRATCH3: w_rdata = r_scr3;
      REG_SAMPLE:
        w_rdata = {{(32-C_SAMPLE_WIDTH){1'b0}}, w_sample};
      REG_COUNT:    w_rdata = w_count;
      REG_STATUS:   w_rdata = {31'd0, w_new_sample};
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.S_AXI_ARVALID & ~r_arready & ~r_rvalid;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (r_rvalid & s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  read_xadc_sample_cap #(
    .C_SAMPLE_WIDTH(C_SAMPLE_WIDTH)
  ) u_cap (
    .clk          (S_AXI_ACLK),
    .rst_n        (S_AXI_ARESETN),
    .i_capture_en (r_ctrl[CTRL_CAP_EN]),
    .i_clr_cnt    (w_clr_cnt),
    .i_rd_clr     (w_rd_clr),
    .i_drdy       (xadc_drdy),
    .i_do         (xadc_do),
    .o_sample     (w_sample),
    .o_count      (w_count),
    .o_new_sample (w_new_sample)
  );

`ifdef READ_XADC_IRQ_EN
  logic r_irq;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_irq <= 1'b0;
    else r_irq <= w_new_sample & r_ctrl[CTRL_IRQ_EN];
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_read_xadc_axil_slave.sv
// Directed bench for read_xadc_axil_slave: register map, strobes,
// capture, handshake ordering, simultaneous events and reset.
module tb_read_xadc_axil_slave;

`ifdef READ_XADC_IRQ_EN
  localparam logic        EXP_IRQ   = 1'b1;
  localparam logic [31:0] EXP_CTRL7 = 32'h3;
`else
  localparam logic        EXP_IRQ   = 1'b0;
  localparam logic [31:0] EXP_CTRL7 = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] xadc_do = '0;
  logic        xadc_drdy = 1'b0;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  read_xadc_axil_slave_if #(.AW(5), .DW(32)) axi ();

  read_xadc_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .xadc_do       (xadc_do),
    .xadc_drdy     (xadc_drdy),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int aw_dly,
                        input int w_dly, input int b_hold,
                        input logic pulse);
    int aw_st, w_st, n;
    logic aw_hs, w_hs;
    aw_st = 0;
    w_st = 0;
    axi.S_AXI_AWADDR = a;
    axi.S_AXI_WDATA  = d;
    axi.S_AXI_WSTRB  = s;
    for (int c = 0; c < 40 && !(aw_st == 2 && w_st == 2); c++) begin
      if (aw_st == 0 && c >= aw_dly) begin
        axi.S_AXI_AWVALID = 1'b1;
        aw_st = 1;
      end
      if (w_st == 0 && c >= w_dly) begin
        axi.S_AXI_WVALID = 1'b1;
        w_st = 1;
      end
      aw_hs = axi.S_AXI_AWVALID & axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID & axi.S_AXI_WREADY;
      @(negedge clk);
      if (aw_hs) begin
        axi.S_AXI_AWVALID = 1'b0;
        aw_st = 2;
      end
      if (w_hs) begin
        axi.S_AXI_WVALID = 1'b0;
        w_st = 2;
      end
    end
    chk("aw_w_accept", {30'd0, aw_st == 2, w_st == 2}, 32'h3);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    if (pulse) xadc_drdy = 1'b1;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    xadc_drdy = 1'b0;
    chk("bvalid", {31'd0, axi.S_AXI_BVALID}, 32'h1);
    chk("bresp", {30'd0, axi.S_AXI_BRESP}, 32'h0);
    if (b_hold > 0) begin
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
      for (int h = 0; h < b_hold; h++) begin
        @(negedge clk);
        chk("hold_rdy", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY},
            32'h0);
        chk("hold_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'h1);
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", {31'd0, axi.S_AXI_BVALID}, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    axi_wr(a, d, 4'hF, 0, 0, 0, 1'b0);
  endtask

  task automatic axi_rd(input logic [4:0] a, input logic pulse,
                        output logic [31:0] d);
    int n;
    logic hs;
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (axi.S_AXI_ARVALID && n < 20) begin
      hs = axi.S_AXI_ARREADY;
      if (hs && pulse) xadc_drdy = 1'b1;
      @(negedge clk);
      xadc_drdy = 1'b0;
      if (hs) axi.S_AXI_ARVALID = 1'b0;
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!axi.S_AXI_RVALID && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rvalid", {31'd0, axi.S_AXI_RVALID}, 32'h1);
    chk("rresp", {30'd0, axi.S_AXI_RRESP}, 32'h0);
    d = axi.S_AXI_RDATA;
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(a, 1'b0, d);
    chk(tag, d, exp);
  endtask

  task automatic drdy_pulse(input logic [15:0] v);
    @(negedge clk);
    xadc_do   = v;
    xadc_drdy = 1'b1;
    @(negedge clk);
    xadc_drdy = 1'b0;
  endtask

  logic [31:0] rv;

  initial begin
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY,
        axi.S_AXI_ARREADY}, 32'h0);
    chk("rst_valid", {30'd0, axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 32'h0);
    chk("rst_rdata", axi.S_AXI_RDATA, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("rst_ctrl", 5'h00, 32'h0);
    rd_chk("rst_count", 5'h14, 32'h0);

    wr(5'h00, 32'h1);
    wr(5'h04, 32'h2);
    wr(5'h08, 32'h3);
    wr(5'h0C, 32'h4);
    rd_chk("ctrl", 5'h00, 32'h1);
    rd_chk("scr1", 5'h04, 32'h2);
    rd_chk("scr2", 5'h08, 32'h3);
    rd_chk("scr3", 5'h0C, 32'h4);
    wr(5'h00, 32'h7);
    rd_chk("ctrl_mask", 5'h00, EXP_CTRL7);
    rd_chk("rsvd7", 5'h1C, 32'h0);
    rd_chk("addr_lsb", 5'h0B, 32'h3);

    wr(5'h04, 32'h0);
    axi_wr(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1'b0);
    rd_chk("strb", 5'h04, 32'h00BB00DD);

    wr(5'h00, 32'h5);
    drdy_pulse(16'h0123);
    drdy_pulse(16'h0456);
    drdy_pulse(16'h0789);
    rd_chk("status1", 5'h18, 32'h1);
    rd_chk("count3", 5'h14, 32'h3);
    rd_chk("sample", 5'h10, 32'h0789);
    rd_chk("status0", 5'h18, 32'h0);

    wr(5'h00, 32'h0);
    drdy_pulse(16'h0AAA);
    rd_chk("cap_off_smp", 5'h10, 32'h0789);
    rd_chk("cap_off_cnt", 5'h14, 32'h3);

    wr(5'h00, 32'h1);
    axi_wr(5'h08, 32'h11111111, 4'hF, 0, 3, 5, 1'b0);
    rd_chk("aw_first", 5'h08, 32'h11111111);
    axi_wr(5'h0C, 32'h22222222, 4'hF, 3, 0, 5, 1'b0);
    rd_chk("w_first", 5'h0C, 32'h22222222);

    xadc_do = 16'h0555;
    axi_wr(5'h00, 32'h5, 4'hF, 0, 0, 0, 1'b1);
    rd_chk("clr_cap_cnt", 5'h14, 32'h1);
    rd_chk("clr_cap_smp", 5'h10, 32'h0555);

    wr(5'h10, 32'hFFFFFFFF);
    wr(5'h14, 32'hFFFFFFFF);
    rd_chk("ro_sample", 5'h10, 32'h0555);
    rd_chk("ro_count", 5'h14, 32'h1);

    wr(5'h00, 32'h3);
    drdy_pulse(16'h0ABC);
    chk("irq_early", {31'd0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, {31'd0, EXP_IRQ});
    rd_chk("irq_smp", 5'h10, 32'h0ABC);
    chk("irq_clr", {31'd0, irq}, 32'h0);

    wr(5'h00, 32'h1);
    xadc_do = 16'h0DEF;
    axi_rd(5'h10, 1'b1, rv);
    chk("rd_cap_old", rv, 32'h0ABC);
    rd_chk("rd_cap_sticky", 5'h18, 32'h1);
    rd_chk("rd_cap_new", 5'h10, 32'h0DEF);
    rd_chk("rd_cap_cnt", 5'h14, 32'h3);

    @(negedge clk);
    axi.S_AXI_AWADDR  = 5'h04;
    axi.S_AXI_WDATA   = 32'h12345678;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY},
        32'h0);
    chk("mid_rst_b", {31'd0, axi.S_AXI_BVALID}, 32'h0);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_nob", {31'd0, axi.S_AXI_BVALID}, 32'h0);
    rd_chk("mid_rst_scr1", 5'h04, 32'h0);
    rd_chk("mid_rst_ctrl", 5'h00, 32'h0);
    rd_chk("mid_rst_cnt", 5'h14, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
